// File: rtl/scan_index_gen.sv
// scan_index_gen: timed 0..IDX_MAX index for a 3-to-8 decoder select, with tick/wrap strobes
// Optional ping-pong mode is compiled in with the SCAN_PINGPONG_EN macro.
module scan_index_gen #(
  parameter int DIV = 25000000,
  parameter int IDX_MAX = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       mode_pp,
  output logic [2:0] idx,
  output logic       tick,
  output logic       wrap
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [2:0] MX = 3'(IDX_MAX);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [W-1:0] div_cnt;
  logic dn, rev, adv, at_end;
  logic [2:0] nidx;
`ifdef SCAN_PINGPONG_EN
  logic dir_r;
  assign rev = mode_pp;
  assign dn = mode_pp ? dir_r : dir;
`else
  logic unused_pp;
  assign unused_pp = mode_pp;
  assign rev = 1'b0;
  assign dn = dir;
`endif
  always_comb begin
    adv = state == RUN ? en && div_cnt == LAST : step;
    at_end = dn ? idx == 3'd0 : idx == MX;
    nidx = MX == 3'd0 ? 3'd0
         : !at_end ? (dn ? idx - 3'd1 : idx + 3'd1)
         : rev ? (dn ? 3'd1 : MX - 3'd1)
         : (dn ? MX : 3'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cnt <= '0;
      idx <= 3'd0;
      tick <= 1'b0;
      wrap <= 1'b0;
`ifdef SCAN_PINGPONG_EN
      dir_r <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        idx <= 32'(load_val) > IDX_MAX ? MX : load_val;
        div_cnt <= '0;
`ifdef SCAN_PINGPONG_EN
        dir_r <= dir;
`endif
      end else begin
        if (adv) begin
          idx <= nidx;
          tick <= 1'b1;
          wrap <= at_end;
        end
`ifdef SCAN_PINGPONG_EN
        if (!mode_pp)
          dir_r <= dir;
        else if (adv && at_end)
          dir_r <= ~dir_r;
`endif
        if (state == IDLE) begin
          div_cnt <= '0;
          if (en) state <= RUN;
        end else if (!en) begin
          state <= IDLE;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt == LAST ? '0 : div_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_scan_index_gen.sv
// tb_scan_index_gen: scoreboard bench; main DUT DIV=4/IDX_MAX=7, side DUTs for IDX_MAX=5 and DIV=1
module tb_scan_index_gen;
  logic clk = 0, rst = 1, en = 0, dir = 0, step = 0, load = 0, mode_pp = 0;
  logic [2:0] load_val = 0;
  logic [2:0] idx0, idx1, idx2;
  logic tick0, wrap0, tick2, unused_t1, unused_w1, unused_w2;
  int cyc = 0, nchk = 0, nfail = 0;
  typedef struct {logic [2:0] i; logic w; int c;} exp_t;
  exp_t q[$];
  int ppseq[10] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  scan_index_gen #(.DIV(4), .IDX_MAX(7)) u0 (.clk(clk), .rst(rst), .en(en), .dir(dir), .step(step),
    .load(load), .load_val(load_val), .mode_pp(mode_pp), .idx(idx0), .tick(tick0), .wrap(wrap0));
  scan_index_gen #(.DIV(4), .IDX_MAX(5)) u1 (.clk(clk), .rst(rst), .en(en), .dir(dir), .step(step),
    .load(load), .load_val(load_val), .mode_pp(mode_pp), .idx(idx1), .tick(unused_t1), .wrap(unused_w1));
  scan_index_gen #(.DIV(1), .IDX_MAX(7)) u2 (.clk(clk), .rst(rst), .en(en), .dir(dir), .step(step),
    .load(load), .load_val(load_val), .mode_pp(mode_pp), .idx(idx2), .tick(tick2), .wrap(unused_w2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic wait_cy(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_tick(input int i, input int w, input int c);
    q.push_back('{3'(i), 1'(w), c});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (tick0) begin
        if (q.size() == 0) chk("spurious_tick", 1, 0);
        else begin
          e = q.pop_front();
          chk("tick_idx", idx0, e.i);
          chk("tick_wrap", wrap0, e.w);
          chk("tick_cycle", cyc, e.c);
        end
      end else chk("wrap_without_tick", wrap0, 0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    wait_cy(2);
    chk("reset_idx", idx0, 0);
    chk("reset_tick", tick0, 0);
    chk("reset_wrap", wrap0, 0);
    rst = 0; en = 1;
    t = cyc;
    for (int k = 1; k <= 8; k++) exp_tick(k % 8, k == 8, t + 1 + 4 * k);
    wait_cy(33);
    dir = 1;
    t = cyc;
    exp_tick(7, 1, t + 4);
    exp_tick(6, 0, t + 8);
    exp_tick(7, 0, t + 12);
    wait_cy(10);
    dir = 0;
    wait_cy(2);
    en = 0;
    wait_cy(1);
    load = 1; load_val = 5;
    wait_cy(1);
    load = 0;
    chk("load_idle_idx", idx0, 5);
    chk("load_idle_tick", tick0, 0);
    for (int k = 0; k < 3; k++) begin
      step = 1;
      exp_tick((6 + k) % 8, k == 2, cyc + 1);
      wait_cy(1);
      step = 0;
      wait_cy(1);
    end
    en = 1;
    t = cyc;
    exp_tick(1, 0, t + 5);
    wait_cy(1);
    step = 1;
    wait_cy(1);
    step = 0;
    wait_cy(6);
    load = 1; load_val = 3;
    wait_cy(1);
    load = 0;
    chk("load_on_tick_idx", idx0, 3);
    chk("load_on_tick_tick", tick0, 0);
    exp_tick(4, 0, cyc + 4);
    wait_cy(4);
    load = 1; load_val = 6;
    exp_tick(7, 0, cyc + 5);
    wait_cy(1);
    load = 0;
    chk("load6_idx", idx0, 6);
    chk("load_clamp_max5", idx1, 5);
    wait_cy(4);
    load = 1; load_val = 4;
    wait_cy(1);
    load = 0;
    wait_cy(2);
    chk("pre_reset_idx", idx0, 4);
    rst = 1;
    wait_cy(1);
    chk("midrun_reset_idx", idx0, 0);
    chk("midrun_reset_tick", tick0, 0);
    chk("midrun_reset_wrap", wrap0, 0);
    rst = 0;
    t = cyc;
    exp_tick(1, 0, t + 5);
    wait_cy(1);
    for (int k = 1; k <= 4; k++) begin
      wait_cy(1);
      chk("div1_tick", tick2, 1);
      chk("div1_idx", idx2, k);
    end
    load = 1; load_val = 5; mode_pp = 1;
    wait_cy(1);
    load = 0;
    t = cyc;
    for (int j = 0; j < 10; j++) begin
`ifdef SCAN_PINGPONG_EN
      exp_tick(ppseq[j], j == 2 || j == 9, t + 4 * (j + 1));
`else
      exp_tick((6 + j) % 8, j == 2, t + 4 * (j + 1));
`endif
    end
    wait_cy(40);
    en = 0;
    wait_cy(3);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/scan_index_gen.md
Name: scan_index_gen

Overview:
- Timed 3-bit index generator that drives the select input of the board's 3-to-8 one-hot decoder, for LED chase and digit-scan displays.
- Divides the system clock down to a step rate and advances a 0..IDX_MAX index up or down with wrap-around.
- Supports run/stop, manual single-step, and synchronous load.
- Emits tick and wrap strobes so downstream logic can align to index changes.

Parameters:
DIV, 25000000, clock cycles per automatic advance while running (legal range >= 1); prescaler width is $clog2(DIV), minimum 1 bit
IDX_MAX, 7, last index value (legal range 0..7); the index range is 0..IDX_MAX

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
en  input  1  1 = run (automatic advance every DIV cycles), 0 = stopped
dir  input  1  0 = count up, 1 = count down
step  input  1  single-cycle strobe; advances the index once, only while stopped
load  input  1  single-cycle strobe; loads load_val into the index
load_val  input  3  value to load
mode_pp  input  1  ping-pong mode select (functional only with the optional feature)
idx  output  3  current index, to the decoder select input
tick  output  1  one-cycle pulse, high in the first cycle idx holds a newly advanced value
wrap  output  1  one-cycle pulse, coincident with tick, when the advance crossed an end of the range

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: idx=0, tick=0, wrap=0, state=IDLE, div_cnt=0, internal direction dir_r=up. rst has priority over every other input, including mid-count.
- States:
  - IDLE: div_cnt held at 0. Goes to RUN on the next edge when en=1.
  - RUN: div_cnt counts 0..DIV-1 and returns to 0. Goes to IDLE on the next edge when en=0, and div_cnt clears.
- Advance events:
  - In RUN: the edge where div_cnt==DIV-1 updates idx and registers tick=1, so tick is visible together with the new idx.
  - In IDLE: step=1 causes one advance on the next edge, with tick=1.
  - step is ignored in RUN. With DIV=1, tick is high every RUN cycle.
- Next-index rule (mode_pp inactive):
  - Up: idx==IDX_MAX gives 0 with wrap=1; otherwise idx+1.
  - Down: idx==0 gives IDX_MAX with wrap=1; otherwise idx-1.
  - IDX_MAX=0: idx stays 0 and wrap=1 on every advance.
  - dir is sampled at each advance, so a mid-run change takes effect on the next advance.
- Load:
  - load=1 sets idx to load_val on the next edge; values above IDX_MAX clamp to IDX_MAX.
  - div_cnt clears to 0 and the state is unchanged.
  - tick and wrap are 0 that cycle.
  - load takes priority over a coincident advance or step, and that advance is dropped.
  - load also copies dir into dir_r.
- tick and wrap are high for exactly one cycle per advance and are never high without an advance.
- Entering IDLE mid-count discards the partial count. Re-entering RUN needs a full DIV cycles before the first tick.

Optional Feature:
Macro: SCAN_PINGPONG_EN
- Defined: when mode_pp=1, the direction comes from dir_r and the dir input is ignored.
  - Up at idx==IDX_MAX: dir_r flips to down, idx goes to IDX_MAX-1, wrap=1.
  - Down at idx==0: dir_r flips to up, idx goes to 1, wrap=1.
  - IDX_MAX=0: idx stays 0 with wrap=1.
  - While mode_pp=0, dir_r follows dir every cycle, so switching into ping-pong continues in the current direction.
- Not defined: mode_pp is ignored and dir_r logic is absent. Behaviour is identical to mode_pp=0.

Test Plan:
1. DIV=4, IDX_MAX=7, rst then en=1, dir=0 -> first tick 4 cycles after entering RUN; idx sequence 1,2,...,7,0; wrap only on the 7->0 step; ticks exactly 4 cycles apart.
2. dir=1 from idx=0 -> idx=7 with wrap=1; next advance gives 6 with wrap=0. Flip dir mid-interval -> the next advance follows the new dir.
3. en=0, step pulses x3 from idx=5 -> idx 6,7,0; three ticks, wrap on 0. step while en=1 -> no extra advance.
4. load=1, load_val=3 coincident with a tick edge -> idx=3, tick=0; next tick 4 cycles later. load_val=6 with IDX_MAX=5 -> idx=5.
5. rst asserted mid-RUN at idx=4, div_cnt=2 -> next cycle idx=0, tick=0, wrap=0, IDLE. Also check DIV=1 -> tick every RUN cycle.
6. With SCAN_PINGPONG_EN, mode_pp=1, IDX_MAX=7 -> idx 6,7,6,...,0,1; wrap at each reversal. Without the macro -> same stimulus wraps 7->0.
